// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time writer for the instruction memory. Consumes a little-endian byte
// stream made of a 32-bit word-count header followed by that many 32-bit
// instruction words. Each assembled word is written to the next consecutive
// word address starting at 0, one single-cycle strobe per word. The core is
// held in reset through cpu_rstn_o until the whole image has been consumed.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rstn_i         synchronous active-low reset
//   start_i        single-cycle re-arm pulse, honoured only when done
//   byte_i         stream byte
//   byte_valid_i   byte_i is valid
//   byte_ready_o   loader accepts a byte this cycle
//   mem_we_o       instruction memory write strobe (one cycle per word)
//   mem_addr_o     word address of the write
//   mem_wdata_o    write data
//   busy_o         loading header or data
//   done_o         image fully consumed
//   overflow_o     sticky: header count exceeded DEPTH
//   cpu_rstn_o     active-low core reset, released after the load completes
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic              cpu_rstn_o
);

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t            state_q,     state_d;
    logic [1:0]        byte_cnt_q,  byte_cnt_d;
    logic [23:0]       shift_q,     shift_d;      // bytes 0..2 of the current group
    logic [31:0]       count_q,     count_d;
    logic [31:0]       index_q,     index_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              overflow_q,  overflow_d;
    logic              cpu_rstn_q,  cpu_rstn_d;

    logic              byte_fire;
    logic [31:0]       group_word;

    // Ready is combinational so it drops immediately while reset is asserted.
    assign byte_ready_o = rstn_i && (state_q != S_DONE);
    assign byte_fire    = byte_valid_i && byte_ready_o;

    // Full little-endian group as it stands on the edge accepting byte 3.
    assign group_word   = {byte_i, shift_q};

    always_comb begin
        // NOTE: every _d defaults to its _q (or an idle value) before any
        // branch, so no path through this block can infer a latch.
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        count_d     = count_q;
        index_d     = index_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        overflow_d  = overflow_q;
        cpu_rstn_d  = cpu_rstn_q;

        if (byte_fire) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    shift_d[7:0]   = byte_i;
                2'd1:    shift_d[15:8]  = byte_i;
                2'd2:    shift_d[23:16] = byte_i;
                default: shift_d        = shift_q;
            endcase

            if (byte_cnt_q == 2'd3) begin
                if (state_q == S_LEN) begin
                    count_d = group_word;
                    index_d = 32'd0;
                    if (group_word > DEPTH_W) begin
                        overflow_d = 1'b1;
                    end
                    state_d = (group_word == 32'd0) ? S_DONE : S_DATA;
                end else begin
                    // Words beyond the memory are consumed but never strobed.
                    mem_wdata_d = group_word;
                    mem_addr_d  = index_q[ADDR_W-1:0];
                    mem_we_d    = (index_q < DEPTH_W);
                    index_d     = index_q + 32'd1;
                    if (index_q + 32'd1 == count_q) begin
                        state_d = S_DONE;
                    end
                end
            end
        end

        // Ready is low in S_DONE, so no byte can arrive on the same edge.
        if (state_q == S_DONE) begin
            if (start_i) begin
                state_d    = S_LEN;
                overflow_d = 1'b0;
                index_d    = 32'd0;
                byte_cnt_d = 2'd0;
                cpu_rstn_d = 1'b0;
            end else begin
                // Released one cycle after entry, i.e. after the last strobe.
                cpu_rstn_d = 1'b1;
            end
        end

        busy_d = (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values computed above.
        if (!rstn_i) begin
            state_q     <= S_LEN;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            count_q     <= 32'd0;
            index_q     <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            cpu_rstn_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            index_q     <= index_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            cpu_rstn_q  <= cpu_rstn_d;
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign overflow_o  = overflow_q;
    assign cpu_rstn_o  = cpu_rstn_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Every cycle is driven through step(),
// which advances a byte-count based reference model of the loader and compares
// all outputs. A hand-written vector table covers the basic two-word image;
// directed sequences cover empty image, gaps, overflow, reset mid-load and
// re-arm; a randomized loop covers mixed images with gaps and stray pulses.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int DEPTH  = 4096;
    localparam int ADDR_W = 12;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              start_i;
    logic [7:0]        byte_i;
    logic              byte_valid_i;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;
    logic              cpu_rstn_o;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_i      (start_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o),
        .cpu_rstn_o   (cpu_rstn_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed writes since the last clear.
    int          n_writes;
    logic [31:0] last_addr;
    logic [31:0] last_data;

    // Reference model: everything is derived from the number of accepted
    // bytes since the load was armed.
    longint      m_n;
    longint      m_cnt;
    bit          m_done;
    bit          m_ovf;
    int          m_age;
    logic [7:0]  m_lastb [4];

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
        logic        cr;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n    = 0;
        m_cnt  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_age  = 0;
        for (int i = 0; i < 4; i++) m_lastb[i] = 8'h00;
    endtask

    // One clock cycle: called at a falling edge, drives inputs, passes the
    // rising edge, and compares outputs at the next falling edge.
    task automatic step(input logic v, input logic [7:0] b, input logic st);
        bit          acc;
        bit          prev_done;
        bit          exp_we;
        longint      k;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;

        byte_valid_i = v;
        byte_i       = b;
        start_i      = st;
        #1;
        check("byte_ready", 32'(byte_ready_o), 32'(!m_done));
        acc       = v && !m_done;
        prev_done = m_done;
        exp_we    = 1'b0;
        exp_addr  = 32'd0;
        exp_data  = 32'd0;
        @(negedge clk_i);

        if (st && prev_done) begin
            m_n    = 0;
            m_cnt  = 0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
        end else if (acc) begin
            m_lastb[m_n % 4] = b;
            m_n++;
            if (m_n == 4) begin
                m_cnt  = longint'({m_lastb[3], m_lastb[2], m_lastb[1], m_lastb[0]});
                m_ovf  = (m_cnt > DEPTH);
                m_done = (m_cnt == 0);
            end else if (m_n > 4 && (m_n % 4) == 0) begin
                k        = (m_n - 8) / 4;
                exp_we   = (k < DEPTH);
                exp_addr = 32'(k % DEPTH);
                exp_data = {m_lastb[3], m_lastb[2], m_lastb[1], m_lastb[0]};
                if (k + 1 == m_cnt) m_done = 1'b1;
            end
        end
        if (prev_done && m_done) m_age++;
        else                     m_age = 0;

        check("mem_we", 32'(mem_we_o), 32'(exp_we));
        if (exp_we) begin
            check("mem_addr", 32'(mem_addr_o), exp_addr);
            check("mem_wdata", mem_wdata_o, exp_data);
        end
        check("done", 32'(done_o), 32'(m_done));
        check("busy", 32'(busy_o), 32'(!m_done));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("cpu_rstn", 32'(cpu_rstn_o), 32'(m_done && m_age >= 1));

        if (mem_we_o === 1'b1) begin
            n_writes++;
            last_addr = 32'(mem_addr_o);
            last_data = mem_wdata_o;
        end
    endtask

    task automatic do_reset();
        rstn_i       = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        #1;
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        @(negedge clk_i);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_cpu_rstn", 32'(cpu_rstn_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd1);
        rstn_i   = 1'b1;
        n_writes = 0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit rnd_start);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        for (int g = 0; g < gap; g++) begin
            step(1'b0, 8'h00, rnd_start && ($urandom_range(0, 3) == 0));
        end
        step(1'b1, b, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap, input bit rnd_start);
        send_byte(w[7:0],   max_gap, rnd_start);
        send_byte(w[15:8],  max_gap, rnd_start);
        send_byte(w[23:16], max_gap, rnd_start);
        send_byte(w[31:24], max_gap, rnd_start);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rstn_i       = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        n_writes     = 0;
        last_addr    = 32'd0;
        last_data    = 32'd0;
        model_reset();

        // Two-word image, back to back; outputs after each edge.
        vecs[0]  = '{1'b1, 8'h02, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'h00, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h00, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h13, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[6]  = '{1'b1, 8'h00, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b1, 8'h00, 1'b1, 32'd0, 32'h00000013, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 8'hB7, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h10, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h00, 1'b0, 32'd0, 32'h0,        1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'h00, 1'b1, 32'd1, 32'h000010B7, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1};

        @(negedge clk_i);
        do_reset();

        // Vector table.
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, vecs[i].b, 1'b0);
            check("tbl_we", 32'(mem_we_o), 32'(vecs[i].we));
            if (vecs[i].we) begin
                check("tbl_addr", 32'(mem_addr_o), vecs[i].addr);
                check("tbl_data", mem_wdata_o, vecs[i].data);
            end
            check("tbl_done", 32'(done_o), 32'(vecs[i].done));
            check("tbl_cpu_rstn", 32'(cpu_rstn_o), 32'(vecs[i].cr));
        end

        // Empty image.
        do_reset();
        send_word(32'd0, 0, 1'b0);
        check("empty_done", 32'(done_o), 32'd1);
        idle(1);
        check("empty_cpu_rstn", 32'(cpu_rstn_o), 32'd1);
        check("empty_ovf", 32'(overflow_o), 32'd0);
        check("empty_writes", 32'(n_writes), 32'd0);

        // Two words with random gaps, including inside words.
        do_reset();
        send_word(32'd2, 5, 1'b0);
        send_word(32'h00000013, 5, 1'b0);
        send_word(32'h000010B7, 5, 1'b0);
        idle(2);
        check("gap_writes", 32'(n_writes), 32'd2);
        check("gap_last_addr", last_addr, 32'd1);
        check("gap_last_data", last_data, 32'h000010B7);

        // Header DEPTH+1: the last word is consumed without a strobe.
        do_reset();
        send_word(32'(DEPTH + 1), 0, 1'b0);
        check("ovf_flag_early", 32'(overflow_o), 32'd1);
        for (int i = 0; i <= DEPTH; i++) send_word(32'(i), 0, 1'b0);
        idle(2);
        check("ovf_writes", 32'(n_writes), 32'(DEPTH));
        check("ovf_last_addr", last_addr, 32'(DEPTH - 1));
        check("ovf_last_data", last_data, 32'(DEPTH - 1));
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_done", 32'(done_o), 32'd1);

        // Reset after 6 data bytes of a 2-word image.
        do_reset();
        send_word(32'd2, 0, 1'b0);
        send_word(32'h44332211, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        do_reset();
        send_word(32'd1, 0, 1'b0);
        send_word(32'hDEADBEEF, 0, 1'b0);
        idle(2);
        check("rstmid_writes", 32'(n_writes), 32'd1);
        check("rstmid_addr", last_addr, 32'd0);
        check("rstmid_data", last_data, 32'hDEADBEEF);

        // Re-arm from S_DONE; a start pulse inside S_DATA is ignored.
        step(1'b0, 8'h00, 1'b1);
        check("rearm_done", 32'(done_o), 32'd0);
        check("rearm_cpu_rstn", 32'(cpu_rstn_o), 32'd0);
        check("rearm_ready", 32'(byte_ready_o), 32'd1);
        n_writes = 0;
        send_word(32'd1, 0, 1'b0);
        step(1'b1, 8'h78, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        send_byte(8'h56, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        idle(2);
        check("rearm_writes", 32'(n_writes), 32'd1);
        check("rearm_addr", last_addr, 32'd0);
        check("rearm_data", last_data, 32'h12345678);

        // Randomized images with gaps, stray start pulses and stray bytes.
        for (int t = 0; t < 40; t++) begin
            int nw;
            nw = int'($urandom_range(0, 6));
            send_word(32'(nw), 3, 1'b1);
            for (int w = 0; w < nw; w++) send_word($urandom, 3, 1'b1);
            for (int e = 0; e < 3; e++) step(1'b1, 8'($urandom), 1'b0);
            step(1'b0, 8'h00, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It receives a little-endian byte stream (from the debug UART receiver) made of a 32-bit word-count header followed by that many 32-bit instruction words. It issues one single-cycle write per assembled word to consecutive word addresses starting at 0. The core is held in reset through cpu_rstn_o until the image is fully loaded.

Parameters:
DEPTH, 4096, number of 32-bit words in instruction memory
ADDR_W, 12, word-address width; must equal clog2(DEPTH)

Ports:
clk_i  input  1  system clock, all logic on rising edge
rstn_i  input  1  synchronous active-low reset
start_i  input  1  single-cycle pulse; re-arms loader, honoured only in S_DONE
byte_i  input  8  stream byte
byte_valid_i  input  1  byte_i valid
byte_ready_o  output  1  loader accepts byte this cycle
mem_we_o  output  1  instruction memory write strobe, one cycle per word
mem_addr_o  output  ADDR_W  word address of the write
mem_wdata_o  output  32  write data
busy_o  output  1  high in S_LEN and S_DATA
done_o  output  1  high in S_DONE
overflow_o  output  1  sticky: header count exceeded DEPTH
cpu_rstn_o  output  1  active-low core reset, low until load completes

Behaviour:
- Interface: one clock (clk_i). Reset rstn_i is synchronous and active-low: sampled on the rising edge of clk_i, and a low level resets the block.
- Reset values: state=S_LEN, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, done_o=0, overflow_o=0, cpu_rstn_o=0. byte_ready_o is forced 0 while rstn_i=0. busy_o=1 from the first cycle after reset.
- Handshake: a byte transfers on a rising edge where byte_valid_i=1 and byte_ready_o=1. byte_ready_o=1 in S_LEN and S_DATA, 0 in S_DONE. The loader never back-pressures mid-image.
- Byte order: little-endian. Byte 0 of each group goes to [7:0], byte 3 to [31:24]. A 2-bit byte counter wraps 3->0.
- S_LEN: collect 4 bytes into the 32-bit count register.
  - On the 4th byte: if count=0, go to S_DONE; otherwise go to S_DATA with word index=0.
  - If count>DEPTH, set overflow_o in the same transition.
- S_DATA: collect 4 bytes into a word.
  - On the edge accepting the 4th byte, register mem_wdata_o=word and mem_addr_o=index[ADDR_W-1:0].
  - Set mem_we_o=1 for exactly the following cycle only if index<DEPTH. Write latency is 1 cycle after the 4th byte.
  - Words with index>=DEPTH are consumed and discarded, with mem_we_o kept 0.
  - After each 4th byte, index increments. When index+1=count, go to S_DONE on that same edge; the final write strobe still occurs in the next cycle.
- S_DONE: cpu_rstn_o goes to 1 on the cycle after the final mem_we_o pulse, or 1 cycle after entry when count=0.
  - start_i=1 returns to S_LEN and clears done_o, overflow_o, index and the byte counter; cpu_rstn_o goes to 0 on the same edge.
  - start_i in S_LEN or S_DATA is ignored.
- Idle gaps: byte_valid_i may drop for any number of cycles between or inside words. Partial words are retained.
- Reset mid-load: all state returns to reset values, the partial word and count are discarded, and the next byte is treated as header byte 0. Memory contents already written are not cleared.
- Index and count are 32-bit. Header values up to 2^32-1 are accepted; the loader consumes exactly count words.

Test Plan:
- Header 02 00 00 00, then bytes 13 00 00 00 B7 10 00 00 -> mem_we_o pulses at addr 0 data 0x00000013 and addr 1 data 0x000010B7, each one cycle after the 4th byte. done_o=1, then cpu_rstn_o=1 one cycle later.
- Header 00 00 00 00 -> no mem_we_o, done_o=1, cpu_rstn_o=1 within 2 cycles, overflow_o=0.
- Header 02 00 00 00 with random 0-5 cycle byte_valid_i gaps, including mid-word -> same two writes as the first scenario, no extra strobes.
- Header DEPTH+1 (01 10 00 00 for 4096), stream 4097 words with data=index -> 4096 writes to addresses 0..4095, the last word is consumed without a strobe, overflow_o=1, then done_o=1.
- rstn_i=0 after 6 data bytes of a 2-word image -> no mem_we_o for the partial word. After reset, a fresh header of 1 word with data 0xDEADBEEF -> a single write at addr 0.
- In S_DONE, pulse start_i -> cpu_rstn_o=0 and done_o=0 on the next cycle, byte_ready_o=1. A new 1-word image reloads addr 0. A start_i pulse during S_DATA has no effect.
